sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_if.sv | 25 ++
 rtl/sram_controller.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sram_controller_if.sv
// Bus bundle between the memory stage, the SRAM controller and the external 16-bit SRAM.
// The controller takes the slave view; the pipeline/SRAM side takes the master view.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit memory-stage access into two 16-bit SRAM phases (low half, then high half),
// stalling the pipeline through ready until the second phase has completed.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  sram_controller_if.slave bus
);

  localparam int PW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          is_write_q, is_write_d;
  logic [31:0]   read_data_q, read_data_d;

  logic [31:0]   addr_offset;
  logic [16:0]   word_idx;
  logic          addr_unused;
  logic          phase_last;
  logic          req;

  logic [17:0]   sram_addr_c;
  logic [15:0]   sram_dq_out_c;
  logic          sram_dq_oe_c;
  logic          sram_we_n_c;

  // Addresses below the base simply wrap; the byte offset within a word is dropped.
  assign addr_offset = bus.address - 32'(BASE_ADDR);
  assign word_idx    = addr_offset[18:2];
  assign addr_unused = ^{addr_offset[31:19], addr_offset[1:0]};

  assign req        = bus.wr_en | bus.rd_en;
  assign phase_last = (phase_q == PHASE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          // Simultaneous read and write requests resolve to a write.
          is_write_d = bus.wr_en;
          state_d    = LO;
          phase_d    = '0;
        end
      end
      LO: begin
        if (phase_last) begin
          state_d = HI;
          phase_d = '0;
          if (!is_write_q) begin
            read_data_d[15:0] = bus.sram_dq_in;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      HI: begin
        if (phase_last) begin
          state_d = DONE;
          phase_d = '0;
          if (!is_write_q) begin
            read_data_d[31:16] = bus.sram_dq_in;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        // A request still held here belongs to the access just finished.
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_comb begin
    sram_addr_c   = '0;
    sram_dq_out_c = '0;
    sram_dq_oe_c  = 1'b0;
    sram_we_n_c   = 1'b1;
    if (state_q == LO || state_q == HI) begin
      sram_addr_c = {word_idx, (state_q == HI)};
      if (is_write_q) begin
        sram_we_n_c   = 1'b0;
        sram_dq_oe_c  = 1'b1;
        sram_dq_out_c = (state_q == HI) ? bus.write_data[31:16] : bus.write_data[15:0];
      end
    end
  end

  assign bus.sram_addr   = sram_addr_c;
  assign bus.sram_dq_out = sram_dq_out_c;
  assign bus.sram_dq_oe  = sram_dq_oe_c;
  assign bus.sram_we_n   = sram_we_n_c;
  assign bus.read_data   = read_data_q;
  assign bus.ready       = ((state_q == IDLE) && !req) || (state_q == DONE);

endmodule
